// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter
//   Shares one spiMaster byte port between NUM_CH byte-stream clients.
//   Bursts are granted one at a time. Selection is either fixed priority
//   (lowest index wins) or round-robin. The block also sequences the panel
//   hardware reset, and it aborts any byte that waits too long for
//   spi_send_done.
//
// Ports
//   clk, reset_n                 single clock, asynchronous active-low reset
//   req/req_valid/req_dc/req_last per-channel burst request and byte strobes
//   req_data                     per-channel byte, channel i at [8i+7:8i]
//   req_ready                    same-cycle accept pulse to the granted channel
//   grant                        one-hot bus owner, zero when idle
//   spi_send/spi_data/dc         byte request to spiMaster, held until done
//   spi_send_done                byte-finished pulse from spiMaster
//   oled_rst_n, panel_ready      panel reset sequencing
//   timeout_err                  sticky flag for an aborted byte
module oled_spi_arbiter #(
    parameter int NUM_CH       = 3,
    parameter int RR_MODE      = 0,
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 1000,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     req,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [8*NUM_CH-1:0]   req_data,
    input  logic [NUM_CH-1:0]     req_dc,
    input  logic [NUM_CH-1:0]     req_last,
    output logic [NUM_CH-1:0]     req_ready,
    output logic [NUM_CH-1:0]     grant,
    output logic                  spi_send,
    output logic [7:0]            spi_data,
    output logic                  dc,
    input  logic                  spi_send_done,
    output logic                  oled_rst_n,
    output logic                  panel_ready,
    output logic                  timeout_err
);

    localparam int MAX_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] LOW_END  = CW'(RST_LOW_CYC - 1);
    localparam logic [CW-1:0] WAIT_END = CW'(RST_WAIT_CYC - 1);
    localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;       // granted channel, also the round-robin pointer
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              spi_send_q, spi_send_d;
    logic [7:0]        spi_data_q, spi_data_d;
    logic              dc_q, dc_d;
    logic              last_q, last_d;
    logic              oled_rst_n_q, oled_rst_n_d;
    logic              panel_ready_q, panel_ready_d;
    logic              timeout_err_q, timeout_err_d;

    // Strobes of the currently granted channel.
    logic       g_req, g_valid, g_dc, g_last;
    logic [7:0] g_data;

    assign g_req   = req[ptr_q];
    assign g_valid = req_valid[ptr_q];
    assign g_dc    = req_dc[ptr_q];
    assign g_last  = req_last[ptr_q];
    assign g_data  = req_data[8*int'(ptr_q) +: 8];

    // Arbitration. Round-robin scans from the channel after the last grant;
    // the pointer's reset value makes channel 0 first after reset.
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                cand = IW'((int'(ptr_q) + 1 + k) % NUM_CH);
            end else begin
                cand = IW'(k);
            end
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The accept pulse must fall in the same cycle as the byte it takes.
    // For that reason it is decoded from registered state rather than stored.
    assign req_ready = (state_q == S_LOAD && g_valid) ? grant_q : '0;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        spi_send_d    = spi_send_q;
        spi_data_d    = spi_data_q;
        dc_d          = dc_q;
        last_d        = last_q;
        oled_rst_n_d  = oled_rst_n_q;
        panel_ready_d = panel_ready_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_RST_LOW: begin
                if (cnt_q == LOW_END) begin
                    cnt_d        = '0;
                    oled_rst_n_d = 1'b1;
                    state_d      = S_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == WAIT_END) begin
                    cnt_d         = '0;
                    panel_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = NUM_CH'(1) << pick_idx;
                    ptr_d   = pick_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A valid byte takes precedence over a request drop in the same cycle.
                if (g_valid) begin
                    spi_data_d = g_data;
                    dc_d       = g_dc;
                    last_d     = g_last;
                    spi_send_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_SEND;
                end else if (!g_req) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                // Done is checked first, so it wins over a timeout that ends in the same cycle.
                if (spi_send_done) begin
                    spi_send_d = 1'b0;
                    if (last_q || !g_req) begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (cnt_q == TO_END) begin
                    spi_send_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RST_LOW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RST_LOW;
            cnt_q         <= '0;
            ptr_q         <= PTR_RST;
            grant_q       <= '0;
            spi_send_q    <= 1'b0;
            spi_data_q    <= 8'h00;
            dc_q          <= 1'b0;
            last_q        <= 1'b0;
            oled_rst_n_q  <= 1'b0;
            panel_ready_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            spi_send_q    <= spi_send_d;
            spi_data_q    <= spi_data_d;
            dc_q          <= dc_d;
            last_q        <= last_d;
            oled_rst_n_q  <= oled_rst_n_d;
            panel_ready_q <= panel_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign spi_send    = spi_send_q;
    assign spi_data    = spi_data_q;
    assign dc          = dc_q;
    assign oled_rst_n  = oled_rst_n_q;
    assign panel_ready = panel_ready_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Testbench for oled_spi_arbiter. It runs a fixed-priority instance and a
// round-robin instance side by side. Each instance has its own client
// queues and its own spiMaster responder.
module tb_oled_spi_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic [N-1:0]   req[2], valid[2], dci[2], lasti[2];
    logic [8*N-1:0] data_i[2];
    logic           sdone[2];
    logic [N-1:0]   ready[2], grant[2];
    logic           send[2], dco[2], orst[2], prdy[2], terr[2];
    logic [7:0]     sdata[2];

    oled_spi_arbiter #(.NUM_CH(N), .RR_MODE(0), .RST_LOW_CYC(4), .RST_WAIT_CYC(3), .TIMEOUT_CYC(8)) dut_fp (
        .clk(clk), .reset_n(reset_n), .req(req[0]), .req_valid(valid[0]), .req_data(data_i[0]),
        .req_dc(dci[0]), .req_last(lasti[0]), .req_ready(ready[0]), .grant(grant[0]),
        .spi_send(send[0]), .spi_data(sdata[0]), .dc(dco[0]), .spi_send_done(sdone[0]),
        .oled_rst_n(orst[0]), .panel_ready(prdy[0]), .timeout_err(terr[0]));

    oled_spi_arbiter #(.NUM_CH(N), .RR_MODE(1), .RST_LOW_CYC(4), .RST_WAIT_CYC(3), .TIMEOUT_CYC(8)) dut_rr (
        .clk(clk), .reset_n(reset_n), .req(req[1]), .req_valid(valid[1]), .req_data(data_i[1]),
        .req_dc(dci[1]), .req_last(lasti[1]), .req_ready(ready[1]), .grant(grant[1]),
        .spi_send(send[1]), .spi_data(sdata[1]), .dc(dco[1]), .spi_send_done(sdone[1]),
        .oled_rst_n(orst[1]), .panel_ready(prdy[1]), .timeout_err(terr[1]));

    int total = 0;
    int bad   = 0;

    // Client byte queues: {last, dc, data}, one per dut and channel.
    logic [9:0] cmem[2][N][64];
    int         head[2][N], tail[2][N], drop_after[2][N], bacc[2][N], acc_cnt[2][N];
    logic [N-1:0] accepted[2];

    // Observation logs.
    int slog[2][64];
    int scount[2];
    int glog[2][32];
    int gcount[2];
    logic [N-1:0] gprev[2];
    int maxrun[2], currun[2], dcnt[2];
    bit dsent[2];
    int dly;
    bit hold;

    function automatic int enc(input int c, input logic d, input logic [7:0] b);
        return c * 512 + int'(d) * 256 + int'(b);
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
        return 7;
    endfunction

    task automatic clear_state();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                head[d][c] = 0; tail[d][c] = 0; drop_after[d][c] = -1;
                bacc[d][c] = 0; acc_cnt[d][c] = 0;
            end
            req[d] = '0; valid[d] = '0; dci[d] = '0; lasti[d] = '0; data_i[d] = '0;
            sdone[d] = 1'b0; accepted[d] = '0; scount[d] = 0; gcount[d] = 0; gprev[d] = '0;
            maxrun[d] = 0; currun[d] = 0; dcnt[d] = 0; dsent[d] = 1'b0;
        end
        dly = 3;
        hold = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_state();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push(input int c, input logic d, input logic l, input logic [7:0] b);
        for (int u = 0; u < 2; u++) begin
            cmem[u][c][tail[u][c]] = {l, d, b};
            tail[u][c]++;
        end
    endtask

    // Advances cycle by cycle while playing clients and the spiMaster.
    // mode 0 runs the full budget, mode 1 stops at idle with all queues
    // drained, and mode 2 stops once dut_fp has spi_send high.
    task automatic run(input int maxc, input int mode, output bit ok);
        logic [9:0] e;
        bit idle;
        ok = 1'b0;
        for (int cyc = 0; cyc < maxc; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < N; c++) begin
                    if (accepted[d][c]) begin
                        e = cmem[d][c][head[d][c]];
                        head[d][c]++; acc_cnt[d][c]++; bacc[d][c]++;
                        if (e[9]) bacc[d][c] = 0;
                        else if (drop_after[d][c] > 0 && bacc[d][c] == drop_after[d][c]) begin
                            head[d][c] = tail[d][c];
                            bacc[d][c] = 0;
                        end
                    end
                    if (head[d][c] < tail[d][c]) begin
                        e = cmem[d][c][head[d][c]];
                        req[d][c] = 1'b1; valid[d][c] = 1'b1;
                        dci[d][c] = e[8]; lasti[d][c] = e[9]; data_i[d][c*8 +: 8] = e[7:0];
                    end else begin
                        req[d][c] = 1'b0; valid[d][c] = 1'b0;
                        dci[d][c] = 1'b0; lasti[d][c] = 1'b0; data_i[d][c*8 +: 8] = 8'h00;
                    end
                end
                sdone[d] = 1'b0;
                if (send[d]) begin
                    if (!dsent[d]) begin
                        dcnt[d]++;
                        if (!hold && dcnt[d] >= dly) begin
                            sdone[d] = 1'b1;
                            dsent[d] = 1'b1;
                            if (scount[d] < 64) slog[d][scount[d]] = enc(oh2i(grant[d]), dco[d], sdata[d]);
                            scount[d]++;
                        end
                    end
                    currun[d]++;
                    if (currun[d] > maxrun[d]) maxrun[d] = currun[d];
                end else begin
                    dsent[d] = 1'b0; dcnt[d] = 0; currun[d] = 0;
                end
                if (grant[d] != '0 && gprev[d] == '0 && gcount[d] < 32) begin
                    glog[d][gcount[d]] = int'(grant[d]);
                    gcount[d]++;
                end
                gprev[d] = grant[d];
            end
            #1;
            for (int d = 0; d < 2; d++) accepted[d] = ready[d];
            if (mode == 1) begin
                idle = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    if (grant[d] != '0 || send[d] || accepted[d] != '0) idle = 1'b0;
                    for (int c = 0; c < N; c++) if (head[d][c] < tail[d][c]) idle = 1'b0;
                end
                if (idle) begin ok = 1'b1; break; end
            end else if (mode == 2) begin
                if (send[0]) begin ok = 1'b1; break; end
            end
        end
        if (mode == 0) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        clear_state();
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({grant[d], ready[d], send[d], sdata[d], dco[d], orst[d], prdy[d], terr[d]} !== '0) begin
                bad++;
                $display("FAIL reset_values dut%0d: got grant=%b send=%b data=%h rst_n=%b ready=%b err=%b, want all 0",
                         d, grant[d], send[d], sdata[d], orst[d], prdy[d], terr[d]);
            end
            req[d] = 3'b001;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [4:0] expv;
                expv = {k >= 4, k >= 7, (k == 8 || k == 9) ? 3'b001 : 3'b000};
                total++;
                if ({orst[d], prdy[d], grant[d]} !== expv) begin
                    bad++;
                    $display("FAIL reset_seq dut%0d clk%0d: got {rst_n,ready,grant}=%b want %b",
                             d, k, {orst[d], prdy[d], grant[d]}, expv);
                end
                if (k == 9) req[d] = 3'b000;
            end
        end
        for (int d = 0; d < 2; d++) sdone[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sdone[d] = 1'b0;
            total++;
            if ({send[d], grant[d], terr[d]} !== 5'b0) begin
                bad++;
                $display("FAIL stray_done dut%0d: got send=%b grant=%b err=%b want 0", d, send[d], grant[d], terr[d]);
            end
        end
    endtask

    task automatic test_ch0_burst();
        bit ok;
        logic [7:0] bytes[3];
        bytes = '{8'hAE, 8'hD5, 8'h80};
        do_reset();
        dly = 5;
        for (int i = 0; i < 3; i++) push(0, 1'b0, i == 2, bytes[i]);
        run(300, 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ch0_burst_finish: got busy want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (acc_cnt[d][0] !== 3 || scount[d] !== 3) begin
                bad++;
                $display("FAIL ch0_counts dut%0d: got ready=%0d sent=%0d want 3/3", d, acc_cnt[d][0], scount[d]);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (slog[d][i] !== enc(0, 1'b0, bytes[i])) begin
                    bad++;
                    $display("FAIL ch0_byte%0d dut%0d: got %0h want %0h", i, d, slog[d][i], enc(0, 1'b0, bytes[i]));
                end
            end
            total++;
            if (gcount[d] !== 1 || glog[d][0] !== 1 || grant[d] !== 3'b000) begin
                bad++;
                $display("FAIL ch0_grant dut%0d: got grants=%0d first=%0d now=%b want 1/1/000",
                         d, gcount[d], glog[d][0], grant[d]);
            end
        end
    endtask

    task automatic test_arb();
        bit ok;
        int exp_g[2][6];
        exp_g = '{'{1, 1, 2, 2, 4, 4}, '{1, 2, 4, 1, 2, 4}};
        do_reset();
        dly = int'($urandom_range(1, 4));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++) push(c, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
        run(500, 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL arb_finish: got busy want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (gcount[d] !== 6 || scount[d] !== 6) begin
                bad++;
                $display("FAIL arb_counts dut%0d: got grants=%0d sent=%0d want 6/6", d, gcount[d], scount[d]);
            end
            for (int i = 0; i < 6; i++) begin
                total++;
                if (glog[d][i] !== exp_g[d][i]) begin
                    bad++;
                    $display("FAIL arb_grant%0d dut%0d: got %0d want %0d", i, d, glog[d][i], exp_g[d][i]);
                end
            end
        end
    endtask

    task automatic test_drop();
        bit ok;
        logic [7:0] b0;
        do_reset();
        b0 = 8'($urandom_range(0, 255));
        push(1, 1'b1, 1'b0, b0);
        for (int i = 0; i < 3; i++) push(1, 1'b1, i == 2, 8'($urandom_range(0, 255)));
        drop_after[0][1] = 1;
        drop_after[1][1] = 1;
        run(300, 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL drop_finish: got busy want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (acc_cnt[d][1] !== 1 || scount[d] !== 1 || slog[d][0] !== enc(1, 1'b1, b0) || grant[d] !== 3'b000) begin
                bad++;
                $display("FAIL drop dut%0d: got ready=%0d sent=%0d byte=%0h grant=%b want 1/1/%0h/000",
                         d, acc_cnt[d][1], scount[d], slog[d][0], grant[d], enc(1, 1'b1, b0));
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        hold = 1'b1;
        push(2, 1'b0, 1'b1, 8'h5A);
        run(200, 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_finish: got busy want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (maxrun[d] !== 8 || terr[d] !== 1'b1 || acc_cnt[d][2] !== 1 || scount[d] !== 0 || grant[d] !== 3'b000) begin
                bad++;
                $display("FAIL timeout dut%0d: got send_len=%0d err=%b ready=%0d sent=%0d grant=%b want 8/1/1/0/000",
                         d, maxrun[d], terr[d], acc_cnt[d][2], scount[d], grant[d]);
            end
        end
        hold = 1'b0;
        push(2, 1'b1, 1'b1, 8'hC3);
        run(200, 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_next_finish: got busy want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (scount[d] !== 1 || slog[d][0] !== enc(2, 1'b1, 8'hC3) || terr[d] !== 1'b1 || gcount[d] !== 2) begin
                bad++;
                $display("FAIL timeout_next dut%0d: got sent=%0d byte=%0h err=%b grants=%0d want 1/%0h/1/2",
                         d, scount[d], slog[d][0], terr[d], gcount[d], enc(2, 1'b1, 8'hC3));
            end
        end
    endtask

    // Reference: bursts are whole units; whenever the bus is free, the
    // arbitration rule picks the next channel that still has a burst queued.
    task automatic test_random();
        bit ok;
        int nb[N], blen[N][4], mb[N][16], bi[N], pos[N];
        int exp_s[64];
        int ne, ptr, pick, ch, len, p;
        logic [7:0] b;
        logic dbit;
        for (int iter = 0; iter < 4; iter++) begin
            do_reset();
            dly = int'($urandom_range(1, 6));
            for (int c = 0; c < N; c++) begin
                nb[c] = int'($urandom_range(0, 3));
                p = 0;
                for (int k = 0; k < nb[c]; k++) begin
                    len = int'($urandom_range(1, 4));
                    blen[c][k] = len;
                    for (int j = 0; j < len; j++) begin
                        b = 8'($urandom_range(0, 255));
                        dbit = 1'($urandom_range(0, 1));
                        push(c, dbit, j == len - 1, b);
                        mb[c][p] = enc(c, dbit, b);
                        p++;
                    end
                end
            end
            run(3000, 1, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL random%0d_finish: got busy want idle", iter); end
            for (int d = 0; d < 2; d++) begin
                ne = 0; ptr = N - 1;
                for (int c = 0; c < N; c++) begin bi[c] = 0; pos[c] = 0; end
                for (int it = 0; it < 4 * N; it++) begin
                    pick = -1;
                    for (int k = 0; k < N; k++) begin
                        ch = (d == 1) ? (ptr + 1 + k) % N : k;
                        if (pick < 0 && bi[ch] < nb[ch]) pick = ch;
                    end
                    if (pick < 0) break;
                    for (int j = 0; j < blen[pick][bi[pick]]; j++) begin
                        exp_s[ne] = mb[pick][pos[pick]];
                        ne++; pos[pick]++;
                    end
                    bi[pick]++;
                    ptr = pick;
                end
                total++;
                if (scount[d] !== ne) begin
                    bad++;
                    $display("FAIL random%0d_count dut%0d: got %0d want %0d", iter, d, scount[d], ne);
                end
                for (int i = 0; i < ne && i < scount[d]; i++) begin
                    total++;
                    if (slog[d][i] !== exp_s[i]) begin
                        bad++;
                        $display("FAIL random%0d_byte%0d dut%0d: got %0h want %0h", iter, i, d, slog[d][i], exp_s[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_midreset();
        bit ok;
        do_reset();
        dly = 4;
        push(0, 1'b1, 1'b0, 8'h11);
        push(0, 1'b1, 1'b1, 8'h22);
        run(100, 2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midreset_send: got no spi_send want spi_send high"); end
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({send[d], grant[d], orst[d], prdy[d], ready[d]} !== '0) begin
                bad++;
                $display("FAIL midreset_async dut%0d: got send=%b grant=%b rst_n=%b ready=%b want 0",
                         d, send[d], grant[d], orst[d], prdy[d]);
            end
        end
        clear_state();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if ({orst[d], send[d]} !== {k >= 4, 1'b0}) begin
                    bad++;
                    $display("FAIL midreset_seq dut%0d clk%0d: got rst_n=%b send=%b want %b/0",
                             d, k, orst[d], send[d], k >= 4);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        clear_state();
        test_reset();
        test_ch0_burst();
        test_arb();
        test_drop();
        test_timeout();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
